// File: rtl/mem_port_arbiter.sv
// Two-requester front end for a single-port RAM with combinational read.
// One access is granted per cycle; read data is registered and returned with a one-cycle rvalid pulse.
module mem_port_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FIXED_PRI = 0,
    parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,

    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,

    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    logic [1:0]       req;
    logic [1:0]       we;
    logic [AW-1:0]    addr  [2];
    logic [WIDTH-1:0] wdata [2];
    logic [1:0]       gnt;
    logic             sel;
    logic             any_gnt;

    // last_gnt_reg: 0 = m0 served last, 1 = m1 served last
    logic             last_gnt_reg;
    logic             last_gnt_next;

    assign req      = {m1_req, m0_req};
    assign we       = {m1_we, m0_we};
    assign addr[0]  = m0_addr;
    assign addr[1]  = m1_addr;
    assign wdata[0] = m0_wdata;
    assign wdata[1] = m1_wdata;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (FIXED_PRI != 0) begin
                gnt = 2'b01;
            end else begin
                gnt = last_gnt_reg ? 2'b01 : 2'b10;
            end
        end
    end

    assign sel     = gnt[1];
    assign any_gnt = |gnt;
    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];

    // Writes are blocked while reset is held even though grants still follow requests.
    assign ram_we    = any_gnt & we[sel] & reset_n;
    assign ram_addr  = any_gnt ? addr[sel]  : '0;
    assign ram_wdata = any_gnt ? wdata[sel] : '0;

    always_comb begin
        last_gnt_next = last_gnt_reg;
        if (any_gnt) begin
            last_gnt_next = gnt[1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_reg <= 1'b1;
        end else begin
            last_gnt_reg <= last_gnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic             pend_rd_reg;
            logic [WIDTH-1:0] rdata_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    pend_rd_reg <= 1'b0;
                    rdata_reg   <= '0;
                end else begin
                    pend_rd_reg <= gnt[gi] & ~we[gi];
                    if (gnt[gi] & ~we[gi]) begin
                        rdata_reg <= ram_rdata;
                    end
                end
            end
        end
    endgenerate

    assign m0_rvalid = g_resp[0].pend_rd_reg;
    assign m0_rdata  = g_resp[0].rdata_reg;
    assign m1_rvalid = g_resp[1].pend_rd_reg;
    assign m1_rdata  = g_resp[1].rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance, each with its own RAM.
// Expected read data is queued at grant time and popped by a negedge monitor on rvalid.
module tb_mem_port_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // round-robin instance signals
    logic             m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0]    m0_addr;
    logic [WIDTH-1:0] m0_wdata, m0_rdata;
    logic             m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0]    m1_addr;
    logic [WIDTH-1:0] m1_wdata, m1_rdata;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;

    // fixed-priority instance signals
    logic             f_m0_req, f_m0_we, f_m0_gnt, f_m0_rvalid;
    logic [AW-1:0]    f_m0_addr;
    logic [WIDTH-1:0] f_m0_wdata, f_m0_rdata;
    logic             f_m1_req, f_m1_we, f_m1_gnt, f_m1_rvalid;
    logic [AW-1:0]    f_m1_addr;
    logic [WIDTH-1:0] f_m1_wdata, f_m1_rdata;
    logic             f_ram_we;
    logic [AW-1:0]    f_ram_addr;
    logic [WIDTH-1:0] f_ram_wdata, f_ram_rdata;

    mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIXED_PRI(0)) u_rr (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIXED_PRI(1)) u_fp (
        .clock(clock), .reset_n(reset_n),
        .m0_req(f_m0_req), .m0_we(f_m0_we), .m0_addr(f_m0_addr), .m0_wdata(f_m0_wdata),
        .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_req(f_m1_req), .m1_we(f_m1_we), .m1_addr(f_m1_addr), .m1_wdata(f_m1_wdata),
        .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata)
    );

    // RAMs with combinational read, write at the clock edge
    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] f_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = '0;
            f_mem[i] = '0;
        end
    end
    assign ram_rdata   = mem[ram_addr];
    assign f_ram_rdata = f_mem[f_ram_addr];
    always @(posedge clock) begin
        if (ram_we)   mem[ram_addr]     <= ram_wdata;
        if (f_ram_we) f_mem[f_ram_addr] <= f_ram_wdata;
    end

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] fq0 [$];
    logic [WIDTH-1:0] fq1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: every rvalid must match the oldest queued expectation for that port.
    always @(negedge clock) begin
        if (m0_rvalid) begin
            if (q0.size() == 0) check("rr m0 unexpected rvalid", 32'd1, 32'd0);
            else                check("rr m0_rdata", m0_rdata, q0.pop_front());
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) check("rr m1 unexpected rvalid", 32'd1, 32'd0);
            else                check("rr m1_rdata", m1_rdata, q1.pop_front());
        end
        if (f_m0_rvalid) begin
            if (fq0.size() == 0) check("fp m0 unexpected rvalid", 32'd1, 32'd0);
            else                 check("fp m0_rdata", f_m0_rdata, fq0.pop_front());
        end
        if (f_m1_rvalid) begin
            if (fq1.size() == 0) check("fp m1 unexpected rvalid", 32'd1, 32'd0);
            else                 check("fp m1_rdata", f_m1_rdata, fq1.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
    endtask

    task automatic fdrive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        f_m0_req = r; f_m0_we = w; f_m0_addr = a; f_m0_wdata = d;
    endtask

    task automatic fdrive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        f_m1_req = r; f_m1_we = w; f_m1_addr = a; f_m1_wdata = d;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);
        fdrive0(1'b0, 1'b0, '0, '0);
        fdrive1(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_m1;
        idle();

        // Reset with both requesting: grants follow requests, RAM writes blocked
        reset_n = 1'b0;
        drive0(1'b1, 1'b1, 5'd3, 8'hFF);
        drive1(1'b1, 1'b0, 5'd4, 8'h00);
        next_cycle();
        next_cycle();
        #2;
        check("reset ram_we", ram_we, 1'b0);
        check("reset m0_rvalid", m0_rvalid, 1'b0);
        check("reset m1_rvalid", m1_rvalid, 1'b0);
        check("reset m0_rdata", m0_rdata, 8'h00);
        check("reset m1_rdata", m1_rdata, 8'h00);
        reset_n = 1'b1;
        #1;
        check("release m0_gnt", m0_gnt, 1'b1);
        check("release m1_gnt", m1_gnt, 1'b0);
        check("release ram_we", ram_we, 1'b1);
        check("release ram_addr", ram_addr, 5'd3);
        next_cycle();

        // m0 write 5 <- A5, then m1 reads it back
        drive0(1'b1, 1'b1, 5'd5, 8'hA5);
        drive1(1'b0, 1'b0, '0, '0);
        #2;
        check("wr m0_gnt", m0_gnt, 1'b1);
        check("wr ram_we", ram_we, 1'b1);
        check("wr ram_addr", ram_addr, 5'd5);
        check("wr ram_wdata", ram_wdata, 8'hA5);
        next_cycle();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b0, 5'd5, 8'h00);
        #2;
        check("rd m1_gnt", m1_gnt, 1'b1);
        check("rd m0_gnt", m0_gnt, 1'b0);
        check("rd ram_we", ram_we, 1'b0);
        check("rd ram_addr", ram_addr, 5'd5);
        q1.push_back(8'hA5);
        next_cycle();
        idle();
        #2;
        check("rd m1_rvalid", m1_rvalid, 1'b1);
        check("rd m0_rvalid", m0_rvalid, 1'b0);
        next_cycle();

        // preload mem[1]=11 (m0) and mem[2]=22 (m1); m1 served last
        drive0(1'b1, 1'b1, 5'd1, 8'h11);
        #2;
        check("pre m0_gnt", m0_gnt, 1'b1);
        next_cycle();
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b1, 5'd2, 8'h22);
        #2;
        check("pre m1_gnt", m1_gnt, 1'b1);
        next_cycle();

        // Round-robin: both read for 6 cycles, grants alternate starting with m0
        for (int i = 0; i < 6; i++) begin
            drive0(1'b1, 1'b0, 5'd1, 8'h00);
            drive1(1'b1, 1'b0, 5'd2, 8'h00);
            #2;
            exp_m1 = (i % 2) == 1;
            check("rr m0_gnt", m0_gnt, !exp_m1);
            check("rr m1_gnt", m1_gnt, exp_m1);
            if (exp_m1) q1.push_back(8'h22);
            else        q0.push_back(8'h11);
            next_cycle();
        end

        // Idle: RAM pins zeroed, arbitration state held
        idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            check("idle ram_we", ram_we, 1'b0);
            check("idle ram_addr", ram_addr, 5'd0);
            check("idle ram_wdata", ram_wdata, 8'h00);
            check("idle gnt", {m1_gnt, m0_gnt}, 2'b00);
            next_cycle();
        end
        drive0(1'b1, 1'b0, 5'd1, 8'h00);
        drive1(1'b1, 1'b0, 5'd2, 8'h00);
        #2;
        check("tie1 m0_gnt", m0_gnt, 1'b1);
        check("tie1 m1_gnt", m1_gnt, 1'b0);
        q0.push_back(8'h11);
        next_cycle();
        #2;
        check("tie2 m1_gnt", m1_gnt, 1'b1);
        q1.push_back(8'h22);
        next_cycle();

        // Reset mid-cycle while an m1 read is granted
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b0, 5'd1, 8'h00);
        #2;
        check("rst m1_gnt", m1_gnt, 1'b1);
        next_cycle();
        drive1(1'b1, 1'b0, 5'd2, 8'h00);
        #1;
        check("rst pre m1_rvalid", m1_rvalid, 1'b1);
        check("rst pre m1_rdata", m1_rdata, 8'h11);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst now m1_rvalid", m1_rvalid, 1'b0);
        check("rst now m1_rdata", m1_rdata, 8'h00);
        next_cycle();
        #2;
        check("rst held m1_rvalid", m1_rvalid, 1'b0);
        reset_n = 1'b1;
        idle();
        next_cycle();
        #2;
        check("rst after m1_rvalid", m1_rvalid, 1'b0);
        check("rst after m1_rdata", m1_rdata, 8'h00);
        next_cycle();

        // RAM contents survive reset; reset tie goes to m0
        drive0(1'b1, 1'b0, 5'd5, 8'h00);
        drive1(1'b1, 1'b0, 5'd3, 8'h00);
        #2;
        check("post m0_gnt", m0_gnt, 1'b1);
        check("post m1_gnt", m1_gnt, 1'b0);
        q0.push_back(8'hA5);
        next_cycle();
        #2;
        check("post2 m1_gnt", m1_gnt, 1'b1);
        q1.push_back(8'hFF);
        next_cycle();
        idle();
        next_cycle();

        // Fixed priority: m0 wins every tie; m1 granted as soon as m0 drops
        for (int i = 0; i < 4; i++) begin
            fdrive0(1'b1, 1'b1, 5'd7, 8'h40 + 8'(i));
            fdrive1(1'b1, 1'b1, 5'd8, 8'h99);
            #2;
            check("fp m0_gnt", f_m0_gnt, 1'b1);
            check("fp m1_gnt", f_m1_gnt, 1'b0);
            check("fp ram_addr", f_ram_addr, 5'd7);
            check("fp ram_wdata", f_ram_wdata, 8'h40 + 8'(i));
            next_cycle();
        end
        fdrive0(1'b0, 1'b0, '0, '0);
        #2;
        check("fp drop m1_gnt", f_m1_gnt, 1'b1);
        check("fp drop m0_gnt", f_m0_gnt, 1'b0);
        check("fp drop ram_addr", f_ram_addr, 5'd8);
        check("fp drop ram_we", f_ram_we, 1'b1);
        next_cycle();
        fdrive0(1'b1, 1'b0, 5'd7, 8'h00);
        fdrive1(1'b1, 1'b0, 5'd8, 8'h00);
        #2;
        check("fp rd m0_gnt", f_m0_gnt, 1'b1);
        fq0.push_back(8'h43);
        next_cycle();
        fdrive0(1'b0, 1'b0, '0, '0);
        #2;
        check("fp rd m1_gnt", f_m1_gnt, 1'b1);
        fq1.push_back(8'h99);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();

        check("q0 drained", q0.size(), 32'd0);
        check("q1 drained", q1.size(), 32'd0);
        check("fq0 drained", fq0.size(), 32'd0);
        check("fq1 drained", fq1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
